mplier_dot_seq: RTL and testbench
=================================

Name: mplier_dot_seq

Overview:
- Sequencer that sits on both sides of the 8x8 shift-add multiplier.
- Accepts a stream of 8-bit operand pairs over a valid/ready handshake and issues each pair to the multiplier with a start pulse.
- Captures each 16-bit product when the multiplier signals done and accumulates it into a running sum.
- Presents the finished dot product downstream when the pair tagged last has been accumulated.

Parameters:
- ACC_W, 20, accumulator/result width; must be >= 16.
- MAX_WAIT, 31, cycles allowed in WAIT_DONE before timeout.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can take a pair.
- in_a  in  8  multiplier operand (to mul_mplier).
- in_b  in  8  multiplicand operand (to mul_mcand).
- in_last  in  1  pair is the final term of the dot product.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_mplier  out  8  registered operand A.
- mul_mcand  out  8  registered operand B.
- mul_product  in  16  multiplier product.
- mul_done  in  1  multiplier done (high while idle and at completion).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  accumulated sum of products.
- out_terms  out  8  number of products in out_sum (saturates at 255).
- out_ovf  out  1  sum exceeded 2^ACC_W-1 at some point (sticky per result).
- err_timeout  out  1  sticky; multiplier failed to complete.

Behaviour:
- Reset values:
  - in_ready=0, mul_start=0, mul_mplier=0, mul_mcand=0.
  - out_valid=0, out_sum=0, out_terms=0, out_ovf=0, err_timeout=0.
  - Accumulator, term counter, last flag and wait counter all cleared.
  - State=IDLE.
- States: IDLE, ISSUE, ARM, WAIT_DONE, ACCUM, OUTPUT.
- IDLE:
  - in_ready=1 (registered, asserted the cycle after entering IDLE).
  - A transfer occurs on a clock edge with in_valid=1 and in_ready=1.
  - On transfer: latch in_a→mul_mplier, in_b→mul_mcand and in_last→last flag; in_ready drops to 0; go to ISSUE.
  - Without in_valid, stay in IDLE.
- ISSUE:
  - mul_start=1 for exactly this one cycle; go to ARM.
- ARM:
  - One cycle; mul_done is ignored here, because done is high before the multiplier has loaded.
  - Clear the wait counter; go to WAIT_DONE.
- WAIT_DONE:
  - Wait for mul_done=1.
  - On the edge where mul_done=1, capture mul_product and go to ACCUM.
  - Wait counter increments each cycle. If it reaches MAX_WAIT: set err_timeout=1, treat the product as 0, go to ACCUM.
- ACCUM:
  - acc <= acc + zero-extended product, computed at ACC_W+1 bits; the carry-out sets the sticky ovf flag.
  - acc wraps modulo 2^ACC_W.
  - Term counter increments, saturating at 255.
  - If last flag set: go to OUTPUT. Otherwise go to IDLE.
- OUTPUT:
  - out_valid=1 and out_sum/out_terms/out_ovf hold stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid<=0, acc, term counter and ovf clear, go to IDLE.
  - in_ready stays 0 throughout OUTPUT.
- Latency: ISSUE→ACCUM is the multiplier latency + 2 cycles; a pair with in_last yields out_valid 2 cycles after mul_done is sampled high.
- mul_mplier/mul_mcand hold their value from the transfer until the next transfer. The multiplier samples them at its load.
- Reset asserted in any state, including WAIT_DONE mid-multiply, returns everything to reset values on that edge.
  - mul_start is not reissued.
  - A multiply still in flight completes harmlessly; its done is swallowed by the ARM rule on the next issue.
- err_timeout clears only on reset. Operation continues after a timeout.
- in_last on the very first pair gives a single-term result with out_terms=1.

Test Plan:
- Single pair: a=8'd3, b=8'd5, last=1 → one mul_start pulse; out_valid with out_sum=15, out_terms=1, out_ovf=0.
- Four-term dot product: (255,255),(2,3),(0,77),(16,16) with last on the 4th → out_sum=65025+6+0+256=65287, out_terms=4; in_ready low while each multiply is busy.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → out_sum stable, in_ready=0; release → next pair accepted, accumulator restarts from 0.
- Overflow (ACC_W=16): (255,255) then (255,255),last → out_sum=(130050 mod 65536)=64514, out_ovf=1.
- Timeout: model a multiplier that never raises done after start → err_timeout=1 after MAX_WAIT cycles; last=1 gives out_sum=0.
- Reset mid-operation: assert reset in WAIT_DONE of the second of three terms → all outputs 0 next cycle; a fresh pair (7,9,last) then gives out_sum=63, out_terms=1.

Source files
------------

// File: rtl/mplier_dot_seq_if.sv
// Bundle of the sequencer's three handshakes: operand stream in, multiplier
// issue/return, and dot-product result out.
interface mplier_dot_seq_if #(
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             mul_start;
  logic [7:0]       mul_mplier;
  logic [7:0]       mul_mcand;
  logic [15:0]      mul_product;
  logic             mul_done;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_terms;
  logic             out_ovf;
  logic             err_timeout;

  // Environment side: operand source, multiplier and result sink.
  modport master (
    output in_valid, in_a, in_b, in_last, mul_product, mul_done, out_ready,
    input  in_ready, mul_start, mul_mplier, mul_mcand,
           out_valid, out_sum, out_terms, out_ovf, err_timeout
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_product, mul_done, out_ready,
    output in_ready, mul_start, mul_mplier, mul_mcand,
           out_valid, out_sum, out_terms, out_ovf, err_timeout
  );
endinterface

// File: rtl/mplier_dot_seq.sv
// Dot-product sequencer: feeds operand pairs to an 8x8 shift-add multiplier,
// accumulates the products and hands the finished sum downstream.
module mplier_dot_seq #(
  parameter int ACC_W    = 20,
  parameter int MAX_WAIT = 31
) (
  input  logic           clock,
  input  logic           reset,
  mplier_dot_seq_if.slave bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    ARM       = 3'd2,
    WAIT_DONE = 3'd3,
    ACCUM     = 3'd4,
    OUTPUT    = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              in_ready_r;
  logic              mul_start_r;
  logic [7:0]        mplier_r;
  logic [7:0]        mcand_r;
  logic              last_r;
  logic [WAIT_W-1:0] wait_r;
  logic [15:0]       product_r;
  logic [ACC_W-1:0]  acc_r;
  logic [7:0]        terms_r;
  logic              ovf_r;
  logic              out_valid_r;
  logic [ACC_W-1:0]  out_sum_r;
  logic [7:0]        out_terms_r;
  logic              out_ovf_r;
  logic              err_timeout_r;

  logic              transfer_s;
  logic              expire_s;
  logic              release_s;
  logic [ACC_W:0]    prod_ext_s;
  logic [ACC_W:0]    sum_s;
  logic [7:0]        terms_next_s;

  // Handshake qualifiers and the widened accumulate whose top bit is the carry-out.
  always_comb begin
    transfer_s   = (state_r == IDLE) && in_ready_r && bus.in_valid;
    expire_s     = (state_r == WAIT_DONE) && !bus.mul_done && (wait_r == WAIT_LAST);
    release_s    = (state_r == OUTPUT) && bus.out_ready;
    prod_ext_s   = '0;
    prod_ext_s[15:0] = product_r;
    sum_s        = {1'b0, acc_r} + prod_ext_s;
    if (terms_r == 8'd255) begin
      terms_next_s = terms_r;
    end else begin
      terms_next_s = terms_r + 8'd1;
    end
  end

  // Next-state logic; mul_done is deliberately not looked at in ARM because
  // the multiplier still reports idle-done until it has loaded the operands.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (transfer_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE:     state_s = ARM;
      ARM:       state_s = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.mul_done || expire_s) begin
          state_s = ACCUM;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      ACCUM: begin
        if (last_r) begin
          state_s = OUTPUT;
        end else begin
          state_s = IDLE;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = OUTPUT;
        end
      end
      default:   state_s = IDLE;
    endcase
  end

  // State register and datapath; all outputs come straight from flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      in_ready_r    <= 1'b0;
      mul_start_r   <= 1'b0;
      mplier_r      <= 8'd0;
      mcand_r       <= 8'd0;
      last_r        <= 1'b0;
      wait_r        <= '0;
      product_r     <= 16'd0;
      acc_r         <= '0;
      terms_r       <= 8'd0;
      ovf_r         <= 1'b0;
      out_valid_r   <= 1'b0;
      out_sum_r     <= '0;
      out_terms_r   <= 8'd0;
      out_ovf_r     <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_r == IDLE) && !transfer_s;
      mul_start_r <= transfer_s;

      if (transfer_s) begin
        mplier_r <= bus.in_a;
        mcand_r  <= bus.in_b;
        last_r   <= bus.in_last;
      end

      if (state_r == ARM) begin
        wait_r <= '0;
      end else if (state_r == WAIT_DONE) begin
        wait_r <= wait_r + WAIT_W'(1);
      end

      // A stalled multiplier contributes a zero product and flags the error.
      if (state_r == WAIT_DONE) begin
        if (bus.mul_done) begin
          product_r <= bus.mul_product;
        end else if (expire_s) begin
          product_r     <= 16'd0;
          err_timeout_r <= 1'b1;
        end
      end

      if (state_r == ACCUM) begin
        acc_r   <= sum_s[ACC_W-1:0];
        ovf_r   <= ovf_r | sum_s[ACC_W];
        terms_r <= terms_next_s;
        if (last_r) begin
          out_valid_r <= 1'b1;
          out_sum_r   <= sum_s[ACC_W-1:0];
          out_terms_r <= terms_next_s;
          out_ovf_r   <= ovf_r | sum_s[ACC_W];
        end
      end

      if (release_s) begin
        out_valid_r <= 1'b0;
        acc_r       <= '0;
        terms_r     <= 8'd0;
        ovf_r       <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.mul_start   = mul_start_r;
  assign bus.mul_mplier  = mplier_r;
  assign bus.mul_mcand   = mcand_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_sum     = out_sum_r;
  assign bus.out_terms   = out_terms_r;
  assign bus.out_ovf     = out_ovf_r;
  assign bus.err_timeout = err_timeout_r;

endmodule

// File: tb/tb_mplier_dot_seq.sv
// Bench for mplier_dot_seq: behavioural multiplier with a one-cycle load delay,
// scoreboard of expected dot products, one task per scenario.
module tb_mplier_dot_seq;

  localparam int ACC_W    = 16;
  localparam int MAX_WAIT = 31;
  localparam int MUL_LAT  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mplier_dot_seq_if #(.ACC_W(ACC_W)) bus ();

  mplier_dot_seq #(.ACC_W(ACC_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Multiplier model: loads one edge after start, so done is still high in ARM.
  logic        m_pend = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_hang = 1'b0;
  logic [7:0]  m_cnt  = 8'd0;
  logic [7:0]  m_a    = 8'd0;
  logic [7:0]  m_b    = 8'd0;
  logic [15:0] m_prod = 16'd0;
  assign bus.mul_done    = !m_busy;
  assign bus.mul_product = m_prod;

  always @(posedge clock) begin
    m_pend <= bus.mul_start;
    if (m_pend) begin
      m_busy <= 1'b1;
      m_cnt  <= m_hang ? 8'd200 : 8'(MUL_LAT);
      m_a    <= bus.mul_mplier;
      m_b    <= bus.mul_mcand;
    end else if (m_busy) begin
      if (m_cnt == 8'd1) begin
        m_busy <= 1'b0;
        m_prod <= 16'(m_a) * 16'(m_b);
      end else begin
        m_cnt <= m_cnt - 8'd1;
      end
    end
  end

  int start_cnt      = 0;
  int busy_ready_cnt = 0;
  always @(posedge clock) if (bus.mul_start) start_cnt <= start_cnt + 1;
  always @(negedge clock) if (m_busy && bus.in_ready) busy_ready_cnt <= busy_ready_cnt + 1;

  typedef struct packed {
    logic [15:0] sum;
    logic [7:0]  terms;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] sb_acc   = 16'd0;
  logic [7:0]  sb_terms = 8'd0;
  logic        sb_ovf   = 1'b0;
  int          n_cmp    = 0;
  int          n_bad    = 0;

  function automatic exp_t pop_exp();
    exp_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  task automatic sb_clear();
    sb_acc = 16'd0; sb_terms = 8'd0; sb_ovf = 1'b0;
  endtask

  // Offer one pair, wait for acceptance and record the expected outcome.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last,
                           input bit hung);
    bit          ok;
    logic [16:0] t;
    exp_t        e;
    @(negedge clock);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_last = last;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_accept: in_ready never rose for pair (%0d,%0d)", a, b);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    t = {1'b0, sb_acc} + (hung ? 17'd0 : 17'(a) * 17'(b));
    sb_acc = t[15:0];
    sb_ovf = sb_ovf | t[16];
    if (sb_terms != 8'd255) sb_terms = sb_terms + 8'd1;
    if (last) begin
      e.sum = sb_acc; e.terms = sb_terms; e.ovf = sb_ovf;
      exp_q.push_back(e);
      sb_clear();
    end
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (bus.out_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic ack_out();
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({bus.in_ready, bus.mul_start, bus.mul_mplier, bus.mul_mcand} !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_issue: ready=%0b start=%0b a=%0d b=%0d, all should be 0",
               bus.in_ready, bus.mul_start, bus.mul_mplier, bus.mul_mcand);
    end
    n_cmp++;
    if ({bus.out_valid, bus.out_sum, bus.out_terms, bus.out_ovf, bus.err_timeout} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_out: valid=%0b sum=%0d terms=%0d ovf=%0b err=%0b, all should be 0",
               bus.out_valid, bus.out_sum, bus.out_terms, bus.out_ovf, bus.err_timeout);
    end
    reset = 1'b0;
    sb_clear();
  endtask

  task automatic test_single();
    bit ok; exp_t e; int s0;
    s0 = start_cnt;
    send_pair(8'd3, 8'd5, 1'b1, 1'b0);
    wait_out(ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || bus.out_sum !== e.sum || bus.out_terms !== e.terms || bus.out_ovf !== e.ovf) begin
      n_bad++;
      $display("FAIL single_result: valid=%0b sum=%0d terms=%0d ovf=%0b, expected sum=%0d terms=%0d ovf=%0b",
               ok, bus.out_sum, bus.out_terms, bus.out_ovf, e.sum, e.terms, e.ovf);
    end
    n_cmp++;
    if (start_cnt - s0 !== 1) begin
      n_bad++; $display("FAIL single_start: %0d start cycles, expected 1", start_cnt - s0);
    end
    n_cmp++;
    if (bus.mul_mplier !== 8'd3 || bus.mul_mcand !== 8'd5) begin
      n_bad++; $display("FAIL single_operands: a=%0d b=%0d, expected 3 5", bus.mul_mplier, bus.mul_mcand);
    end
    ack_out();
  endtask

  task automatic test_dot4();
    bit ok; exp_t e; int b0;
    b0 = busy_ready_cnt;
    send_pair(8'd255, 8'd255, 1'b0, 1'b0);
    send_pair(8'd2, 8'd3, 1'b0, 1'b0);
    send_pair(8'd0, 8'd77, 1'b0, 1'b0);
    send_pair(8'd16, 8'd16, 1'b1, 1'b0);
    wait_out(ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || bus.out_sum !== e.sum || bus.out_terms !== e.terms || bus.out_ovf !== e.ovf) begin
      n_bad++;
      $display("FAIL dot4_result: valid=%0b sum=%0d terms=%0d ovf=%0b, expected sum=%0d terms=%0d ovf=%0b",
               ok, bus.out_sum, bus.out_terms, bus.out_ovf, e.sum, e.terms, e.ovf);
    end
    n_cmp++;
    if (busy_ready_cnt - b0 !== 0) begin
      n_bad++; $display("FAIL dot4_ready_busy: in_ready high on %0d busy cycles, expected 0", busy_ready_cnt - b0);
    end
    ack_out();
  endtask

  task automatic test_back_to_back();
    bit ok; exp_t e; int s0;
    send_pair(8'd4, 8'd4, 1'b1, 1'b0);
    wait_out(ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || bus.out_sum !== e.sum || bus.out_terms !== e.terms) begin
      n_bad++;
      $display("FAIL bp_result: valid=%0b sum=%0d terms=%0d, expected sum=%0d terms=%0d",
               ok, bus.out_sum, bus.out_terms, e.sum, e.terms);
    end
    s0 = start_cnt;
    bus.in_valid = 1'b1; bus.in_a = 8'd6; bus.in_b = 8'd7; bus.in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold: cycle %0d valid=%0b sum=%0d ready=%0b, expected 1 %0d 0",
                 i, bus.out_valid, bus.out_sum, bus.in_ready, e.sum);
      end
    end
    n_cmp++;
    if (start_cnt !== s0) begin
      n_bad++; $display("FAIL bp_no_issue: %0d starts during hold, expected 0", start_cnt - s0);
    end
    ack_out();
    send_pair(8'd6, 8'd7, 1'b1, 1'b0);
    wait_out(ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || bus.out_sum !== e.sum || bus.out_terms !== e.terms || bus.out_ovf !== e.ovf) begin
      n_bad++;
      $display("FAIL bp_restart: valid=%0b sum=%0d terms=%0d ovf=%0b, expected sum=%0d terms=%0d ovf=%0b",
               ok, bus.out_sum, bus.out_terms, bus.out_ovf, e.sum, e.terms, e.ovf);
    end
    ack_out();
  endtask

  task automatic test_overflow();
    bit ok; exp_t e;
    send_pair(8'd255, 8'd255, 1'b0, 1'b0);
    send_pair(8'd255, 8'd255, 1'b1, 1'b0);
    wait_out(ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || bus.out_sum !== e.sum || bus.out_terms !== e.terms || bus.out_ovf !== e.ovf) begin
      n_bad++;
      $display("FAIL ovf_result: valid=%0b sum=%0d terms=%0d ovf=%0b, expected sum=%0d terms=%0d ovf=%0b",
               ok, bus.out_sum, bus.out_terms, bus.out_ovf, e.sum, e.terms, e.ovf);
    end
    ack_out();
  endtask

  task automatic test_timeout();
    bit ok; exp_t e; int cyc;
    n_cmp++;
    if (bus.err_timeout !== 1'b0) begin
      n_bad++; $display("FAIL to_pre: err_timeout=%0b, expected 0", bus.err_timeout);
    end
    m_hang = 1'b1;
    send_pair(8'd9, 8'd9, 1'b1, 1'b1);
    cyc = 0;
    while (!bus.err_timeout && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    n_cmp++;
    if (cyc < MAX_WAIT || cyc > MAX_WAIT + 5) begin
      n_bad++;
      $display("FAIL to_latency: err_timeout after %0d cycles, expected %0d..%0d", cyc, MAX_WAIT, MAX_WAIT + 5);
    end
    m_hang = 1'b0;
    wait_out(ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || bus.out_sum !== e.sum || bus.out_terms !== e.terms || bus.err_timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL to_result: valid=%0b sum=%0d terms=%0d err=%0b, expected sum=%0d terms=%0d err=1",
               ok, bus.out_sum, bus.out_terms, bus.err_timeout, e.sum, e.terms);
    end
    ack_out();
    send_pair(8'd2, 8'd2, 1'b1, 1'b0);
    wait_out(ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || bus.out_sum !== e.sum || bus.err_timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL to_sticky: valid=%0b sum=%0d err=%0b, expected sum=%0d err=1",
               ok, bus.out_sum, bus.err_timeout, e.sum);
    end
    ack_out();
  endtask

  task automatic test_reset_mid();
    bit ok; exp_t e; int s0; int cyc;
    send_pair(8'd1, 8'd2, 1'b0, 1'b0);
    send_pair(8'd3, 8'd4, 1'b0, 1'b0);
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (!bus.mul_start && cyc < 50);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    s0 = start_cnt;
    n_cmp++;
    if ({bus.in_ready, bus.mul_start, bus.mul_mplier, bus.mul_mcand, bus.out_valid,
         bus.out_sum, bus.out_terms, bus.out_ovf, bus.err_timeout} !== 45'd0) begin
      n_bad++;
      $display("FAIL mid_reset: ready=%0b start=%0b a=%0d b=%0d valid=%0b sum=%0d terms=%0d ovf=%0b err=%0b, all should be 0",
               bus.in_ready, bus.mul_start, bus.mul_mplier, bus.mul_mcand, bus.out_valid,
               bus.out_sum, bus.out_terms, bus.out_ovf, bus.err_timeout);
    end
    reset = 1'b0;
    sb_clear();
    repeat (3) @(negedge clock);
    n_cmp++;
    if (start_cnt !== s0) begin
      n_bad++; $display("FAIL mid_no_reissue: %0d starts after reset, expected 0", start_cnt - s0);
    end
    send_pair(8'd7, 8'd9, 1'b1, 1'b0);
    wait_out(ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || bus.out_sum !== e.sum || bus.out_terms !== e.terms || bus.out_ovf !== e.ovf) begin
      n_bad++;
      $display("FAIL mid_fresh: valid=%0b sum=%0d terms=%0d ovf=%0b, expected sum=%0d terms=%0d ovf=%0b",
               ok, bus.out_sum, bus.out_terms, bus.out_ovf, e.sum, e.terms, e.ovf);
    end
    ack_out();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'd0;
    bus.in_b      = 8'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_dot4();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
